fir_pe_n: RTL
=============

FIR_PE_N -- requirements
Module: fir_pe_n

Interface
REQ-001 SHALL have parameter DW, default 8: sample width in bits.
REQ-002 SHALL have parameter CW, default 8: coefficient width in bits.
REQ-003 SHALL have parameter LW, default 4: serial lane width in bits; DW and YW are multiples of LW.
REQ-004 SHALL have parameter YW, default 16: accumulator width in bits.
REQ-005 SHALL have parameter SIGNED, default 0: 0 = unsigned arithmetic, 1 = two's-complement.
REQ-006 SHALL have a single clock and a synchronous active-high reset: clk in, 1 bit, all state on rising edge.
REQ-007 SHALL have port rst in, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port Rdy in, 1 bit: frame-start strobe.
REQ-009 SHALL have port Cin in, CW bits: coefficient, sampled on the Vld cycle.
REQ-010 SHALL have port SatEn in, 1 bit: 1 = saturate, 0 = wrap; sampled on the Vld cycle.
REQ-011 SHALL have port Xin in, LW bits: sample lanes, LS lane first.
REQ-012 SHALL have port Yin in, LW bits: partial-sum lanes, LS lane first.
REQ-013 SHALL have port Xout out, LW bits: forwarded sample lanes.
REQ-014 SHALL have port Yout out, LW bits: result lanes.
REQ-015 SHALL have port Vld out, 1 bit: frame-complete strobe.
REQ-016 SHALL have port Ovf out, 1 bit: sticky overflow flag.

Function
REQ-017 SHALL define NX=DW/LW, NY=YW/LW; elaboration SHALL fail if NX>NY or widths are not multiples of LW.
REQ-018 SHALL use control shift register ctl[NY:0]: ctl[0]<=accepted Rdy, ctl[k+1]<=ctl[k]; beat k is the cycle ctl[k]=1; Vld=ctl[NY].
REQ-019 SHALL accept Rdy only when ctl[NY-1:0]==0, so Rdy is also accepted in the Vld cycle (back-to-back, period NY+1); Rdy at any other time SHALL be ignored.
REQ-020 SHALL capture Xin into sample lane k during beat k, k<NX, and Yin into partial-sum lane k during beat k, k<NY.
REQ-021 SHALL, in the Vld cycle, load y<=acc and acc<=f(X*Cin+Y), with the full-precision product and sum taken before f.
REQ-022 SHALL let f wrap modulo 2^YW when SatEn=0, and clamp to the YW-bit range (unsigned, or signed when SIGNED=1) when SatEn=1.
REQ-023 SHALL set Ovf in the Vld cycle when the full-precision sum is outside the YW-bit range, regardless of SatEn; only rst SHALL clear it.
REQ-024 SHALL drive Xout combinationally with the stored (previous-frame) sample lane k during beat k<NX, and 0 otherwise.
REQ-025 SHALL drive Yout combinationally with y lane k during beat k<NY, and 0 otherwise.
REQ-026 SHALL present the result of frame n on Yout during frame n+2 (two-frame latency); Xout SHALL lag by one frame.

Reset
REQ-027 SHALL, while rst=1, clear ctl, sample and partial-sum registers, acc, y and Ovf to 0 at the next edge, with Vld=0, Xout=0 and Yout=0.
REQ-028 SHALL abandon a frame if rst is asserted mid-frame: no Vld, no acc update, and Rdy ignored while rst=1.

Structure
REQ-029 SHALL keep lane-count helpers and saturation-limit functions, parameterised by width and signedness, in package fir_pe_pkg.
REQ-030 SHALL put multiply-add-saturate in one sub-module fir_pe_mac, purely combinational, which returns the sum and an overflow bit.

Verification (defaults unless stated)
REQ-031 SHALL test reset: rst for 2 cycles -> Vld=0, Xout=0, Yout=0, Ovf=0; no Vld for the next 10 idle cycles.
REQ-032 SHALL test basic MAC: frames with X=0x12, Cin=0x03, Y=0x0005, then two zero frames -> third frame's Yout lanes 0xB,0x3,0x0,0x0 (0x003B); Xout in the second frame = 0x2,0x1.
REQ-033 SHALL test wrap versus saturate: X=0xFF, C=0xFF, Y=0xFFFF gives 0xFE00 with SatEn=0 and 0xFFFF with SatEn=1; Ovf=1 in both cases.
REQ-034 SHALL test signed mode: with SIGNED=1, X=0x80, C=0x7F, Y=0 -> 0xC080 and Ovf=0; then Y=0x8000 with SatEn=1 -> 0x8000 and Ovf=1.
REQ-035 SHALL test handshake: Rdy at beat 2 is ignored (single Vld 5 cycles after the first Rdy); Rdy in the Vld cycle starts a new frame; continuous Rdy gives a Vld every 5 cycles.
REQ-036 SHALL test mid-frame reset: rst at beat 1 -> no Vld, acc and y unchanged from 0, and the next frame works normally.

Source files
------------

// File: rtl/fir_pe_pkg.sv
// Shared helpers for the bit-serial FIR processing element: lane counts and
// saturation limits parameterised by width and signedness.
package fir_pe_pkg;

    localparam int LIM_W = 64;

    function automatic int n_lanes(input int w, input int lw);
        return w / lw;
    endfunction

    function automatic bit lanes_ok(input int w, input int lw);
        return (lw > 0) && (w > 0) && ((w % lw) == 0);
    endfunction

    function automatic logic signed [LIM_W-1:0] sat_max(input int w, input bit sgn);
        logic signed [LIM_W-1:0] one;
        one = 64'sd1;
        return sgn ? (one <<< (w - 1)) - one : (one <<< w) - one;
    endfunction

    function automatic logic signed [LIM_W-1:0] sat_min(input int w, input bit sgn);
        logic signed [LIM_W-1:0] one;
        one = 64'sd1;
        return sgn ? -(one <<< (w - 1)) : '0;
    endfunction

endpackage

// File: rtl/fir_pe_mac.sv
// Combinational multiply-add with optional saturation to the accumulator width;
// reports whether the full-precision sum left the representable range.
module fir_pe_mac
    import fir_pe_pkg::*;
#(
    parameter int DW     = 8,
    parameter int CW     = 8,
    parameter int YW     = 16,
    parameter int SIGNED = 0
) (
    input  logic [DW-1:0] x,
    input  logic [CW-1:0] c,
    input  logic [YW-1:0] y,
    input  logic          sat_en,
    output logic [YW-1:0] sum,
    output logic          ovf
);

    // Two guard bits keep product plus addend exact in either signedness.
    localparam int SW = (((DW + CW) > YW) ? (DW + CW) : YW) + 2;
    localparam logic signed [SW-1:0] MAXV = SW'(sat_max(YW, SIGNED != 0));
    localparam logic signed [SW-1:0] MINV = SW'(sat_min(YW, SIGNED != 0));

    if (SW > LIM_W) begin : g_bad_width
        $error("fir_pe_mac: operand widths exceed limit helper range");
    end

    logic signed [SW-1:0] x_ext;
    logic signed [SW-1:0] c_ext;
    logic signed [SW-1:0] y_ext;
    logic signed [SW-1:0] full;
    logic                 hi;
    logic                 lo;

    always_comb begin
        if (SIGNED != 0) begin
            x_ext = SW'($signed(x));
            c_ext = SW'($signed(c));
            y_ext = SW'($signed(y));
        end else begin
            x_ext = SW'(x);
            c_ext = SW'(c);
            y_ext = SW'(y);
        end
        full = (x_ext * c_ext) + y_ext;
        hi   = full > MAXV;
        lo   = full < MINV;
        ovf  = hi | lo;
        if (sat_en && hi) begin
            sum = MAXV[YW-1:0];
        end else if (sat_en && lo) begin
            sum = MINV[YW-1:0];
        end else begin
            sum = full[YW-1:0];
        end
    end

endmodule

// File: rtl/fir_pe_n.sv
// Bit-serial FIR tap: samples and partial sums arrive LW bits per beat, LS lane
// first; one MAC per frame, result streamed out two frames later.
module fir_pe_n
    import fir_pe_pkg::*;
#(
    parameter int DW     = 8,
    parameter int CW     = 8,
    parameter int LW     = 4,
    parameter int YW     = 16,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Rdy,
    input  logic [CW-1:0] Cin,
    input  logic          SatEn,
    input  logic [LW-1:0] Xin,
    input  logic [LW-1:0] Yin,
    output logic [LW-1:0] Xout,
    output logic [LW-1:0] Yout,
    output logic          Vld,
    output logic          Ovf
);

    localparam int NX = n_lanes(DW, LW);
    localparam int NY = n_lanes(YW, LW);

    if (!lanes_ok(DW, LW) || !lanes_ok(YW, LW) || (NX > NY)) begin : g_bad_cfg
        $error("fir_pe_n: DW and YW must be multiples of LW with DW <= YW");
    end

    logic [NY:0]             ctl;
    logic [NX-1:0][LW-1:0]   x_lanes_p0;
    logic [NY-1:0][LW-1:0]   yin_lanes_p0;
    logic [YW-1:0]           acc_p1;
    logic [YW-1:0]           y_p2;
    logic                    ovf_q;
    logic                    rdy_acc;
    logic [YW-1:0]           mac_sum;
    logic                    mac_ovf;

    // A new frame may start once no beat is in flight, including the Vld cycle.
    assign rdy_acc = Rdy && (ctl[NY-1:0] == '0);

    fir_pe_mac #(
        .DW     (DW),
        .CW     (CW),
        .YW     (YW),
        .SIGNED (SIGNED)
    ) u_mac (
        .x      (x_lanes_p0),
        .c      (Cin),
        .y      (yin_lanes_p0),
        .sat_en (SatEn),
        .sum    (mac_sum),
        .ovf    (mac_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl          <= '0;
            x_lanes_p0   <= '0;
            yin_lanes_p0 <= '0;
            acc_p1       <= '0;
            y_p2         <= '0;
            ovf_q        <= 1'b0;
        end else begin
            ctl <= {ctl[NY-1:0], rdy_acc};
            for (int k = 0; k < NX; k++) begin
                if (ctl[k]) x_lanes_p0[k] <= Xin;
            end
            for (int k = 0; k < NY; k++) begin
                if (ctl[k]) yin_lanes_p0[k] <= Yin;
            end
            // Frame completion: retire the old accumulator, fold in this frame.
            if (ctl[NY]) begin
                y_p2   <= acc_p1;
                acc_p1 <= mac_sum;
                if (mac_ovf) ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        Xout = '0;
        Yout = '0;
        for (int k = 0; k < NX; k++) begin
            if (ctl[k]) Xout = x_lanes_p0[k];
        end
        for (int k = 0; k < NY; k++) begin
            if (ctl[k]) Yout = y_p2[k*LW +: LW];
        end
    end

    assign Vld = ctl[NY];
    assign Ovf = ovf_q;

endmodule
